// File: rtl/tl_memory_access_pkg.sv
// Shared encodings for the MEM stage: ctrl_mem / ctrl_wb bit positions and
// access-size codes, plus the alignment rule used by the stage.
package tl_memory_access_pkg;

  localparam int CTRL_MEM_READ     = 0;
  localparam int CTRL_MEM_WRITE    = 1;
  localparam int CTRL_MEM_SIZE_LO  = 2;
  localparam int CTRL_MEM_SIZE_HI  = 3;
  localparam int CTRL_MEM_UNSIGNED = 4;

  localparam int CTRL_WB_MEMTOREG  = 0;
  localparam int CTRL_WB_REGWRITE  = 1;

  // Code 10 is reserved and behaves as a word access.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_RSVD = 2'b10,
    SIZE_WORD = 2'b11
  } mem_size_e;

  function automatic logic is_aligned(mem_size_e size, logic [1:0] lane);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~lane[0];
      default:   return (lane == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/tl_memory_access_ram.sv
// N_WORDS x 32 data memory with per-byte write enables and a registered read.
// No reset: contents survive a pipeline reset.
module ram_data_byte_en #(
  parameter int N_WORDS = 256,
  parameter int NB_ADDR = $clog2(N_WORDS)
) (
  input  logic               i_clk,
  input  logic [3:0]         i_we,
  input  logic               i_re,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata
);

  logic [31:0] mem [N_WORDS];

  // Byte-lane writes and read-before-write registered read on the same edge.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_re) o_rdata <= mem[i_addr];
  end

endmodule

// File: rtl/tl_memory_access.sv
// MIPS memory-access stage: alignment check, byte-lane store, load extension
// and the MEM/WB pipeline register. One-cycle latency on every output.
module tl_memory_access
  import tl_memory_access_pkg::*;
#(
  parameter int len                  = 32,
  parameter int NB_CTRL_WB           = 2,
  parameter int NB_CTRL_MEM          = 5,
  parameter int NB_ADDRESS_REGISTROS = 5,
  parameter int N_WORDS              = 256
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_enable,
  input  logic [len-1:0]                  i_result_alu,
  input  logic [len-1:0]                  i_write_data,
  input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
  input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
  output logic [len-1:0]                  o_read_data,
  output logic [len-1:0]                  o_result_alu,
  output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
  output logic                            o_misaligned
);

  localparam int NB_WADDR = $clog2(N_WORDS);

  logic [NB_WADDR-1:0] word_idx;
  logic [1:0]          lane;
  mem_size_e           size;
  logic                mem_read;
  logic                mem_write;
  logic                aligned;
  logic [3:0]          be;
  logic [31:0]         wdata;
  logic [31:0]         ram_rdata;
  logic                unused_addr_hi;

  // Upper address bits wrap around and are deliberately ignored.
  assign unused_addr_hi = ^i_result_alu[len-1:NB_WADDR+2];

  assign word_idx  = i_result_alu[NB_WADDR+1:2];
  assign lane      = i_result_alu[1:0];
  assign size      = mem_size_e'(i_ctrl_mem[CTRL_MEM_SIZE_HI:CTRL_MEM_SIZE_LO]);
  assign mem_read  = i_ctrl_mem[CTRL_MEM_READ];
  assign mem_write = i_ctrl_mem[CTRL_MEM_WRITE];
  assign aligned   = is_aligned(size, lane);

  // Lane replication and byte enables for the store path.
  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0;
    case (size)
      SIZE_BYTE: begin
        be    = 4'b0001 << lane;
        wdata = {4{i_write_data[7:0]}};
      end
      SIZE_HALF: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_write_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = i_write_data[31:0];
      end
    endcase
  end

  ram_data_byte_en #(
    .N_WORDS (N_WORDS)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    ((i_enable && mem_write && aligned) ? be : 4'b0000),
    .i_re    (i_enable),
    .i_addr  (word_idx),
    .i_wdata (wdata),
    .o_rdata (ram_rdata)
  );

  logic      rd_valid_q;
  logic [1:0] lane_q;
  mem_size_e size_q;
  logic      unsigned_q;

  // MEM/WB register; the RAM read register sits in parallel with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_valid_q   <= 1'b0;
      lane_q       <= 2'b00;
      size_q       <= SIZE_BYTE;
      unsigned_q   <= 1'b0;
      o_result_alu <= '0;
      o_ctrl_wb    <= '0;
      o_write_reg  <= '0;
      o_misaligned <= 1'b0;
    end else if (i_enable) begin
      // An illegal read+write still writes but yields no load data.
      rd_valid_q   <= mem_read && !mem_write && aligned;
      lane_q       <= lane;
      size_q       <= size;
      unsigned_q   <= i_ctrl_mem[CTRL_MEM_UNSIGNED];
      o_result_alu <= i_result_alu;
      o_ctrl_wb    <= i_ctrl_wb;
      o_write_reg  <= i_write_reg;
      o_misaligned <= (mem_read || mem_write) && !aligned;
    end
  end

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = ram_rdata[{lane_q, 3'b000} +: 8];
  assign sel_half = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

  // Extension on the registered RAM word; gated by the reset-cleared valid bit.
  always_comb begin
    o_read_data = '0;
    if (rd_valid_q) begin
      case (size_q)
        SIZE_BYTE: o_read_data = unsigned_q ? {{(len-8){1'b0}}, sel_byte}
                                            : {{(len-8){sel_byte[7]}}, sel_byte};
        SIZE_HALF: o_read_data = unsigned_q ? {{(len-16){1'b0}}, sel_half}
                                            : {{(len-16){sel_half[15]}}, sel_half};
        default:   o_read_data = len'(ram_rdata);
      endcase
    end
  end

endmodule

// File: tb/tb_tl_memory_access.sv
// Randomised + directed bench for the MEM stage against a word-array model.
module tb_tl_memory_access;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] result_alu;
  logic [31:0] write_data;
  logic [4:0]  ctrl_mem;
  logic [1:0]  ctrl_wb;
  logic [4:0]  write_reg;
  logic [31:0] read_data;
  logic [31:0] res_out;
  logic [1:0]  ctrl_wb_out;
  logic [4:0]  write_reg_out;
  logic        misaligned;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_model [256];
  logic [31:0] exp_rd, exp_res;
  logic [1:0]  exp_wb;
  logic [4:0]  exp_wr;
  logic        exp_mis;

  tl_memory_access dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_result_alu (result_alu),
    .i_write_data (write_data),
    .i_ctrl_mem   (ctrl_mem),
    .i_ctrl_wb    (ctrl_wb),
    .i_write_reg  (write_reg),
    .o_read_data  (read_data),
    .o_result_alu (res_out),
    .o_ctrl_wb    (ctrl_wb_out),
    .o_write_reg  (write_reg_out),
    .o_misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input bit uns);
    logic [31:0] w, v;
    int sh;
    w  = mem_model[a[9:2]];
    sh = 8 * int'(a[1:0]);
    if (sz == 2'b00) begin
      v = (w >> sh) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mask, old;
    int sh;
    old = mem_model[a[9:2]];
    sh  = 8 * int'(a[1:0]);
    if (sz == 2'b00)      mask = 32'hFF << sh;
    else if (sz == 2'b01) mask = 32'hFFFF << sh;
    else                  mask = 32'hFFFF_FFFF;
    mem_model[a[9:2]] = (old & ~mask) | ((d << sh) & mask);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rd"},  read_data,             exp_rd);
    chk({tag, ".res"}, res_out,               exp_res);
    chk({tag, ".wb"},  {30'd0, ctrl_wb_out},  {30'd0, exp_wb});
    chk({tag, ".wr"},  {27'd0, write_reg_out}, {27'd0, exp_wr});
    chk({tag, ".mis"}, {31'd0, misaligned},   {31'd0, exp_mis});
  endtask

  // Drive one instruction, advance one edge, compare against the model.
  task automatic do_cycle(input string tag, input bit en, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [4:0] cm,
                          input logic [1:0] cwb, input logic [4:0] wr);
    bit rd, wrt, uns, ok;
    logic [1:0] sz;
    enable = en; result_alu = alu; write_data = wd;
    ctrl_mem = cm; ctrl_wb = cwb; write_reg = wr;
    rd = cm[0]; wrt = cm[1]; sz = cm[3:2]; uns = cm[4];
    if (sz == 2'b00)      ok = 1'b1;
    else if (sz == 2'b01) ok = (alu[0] == 1'b0);
    else                  ok = (alu[1:0] == 2'b00);
    if (en) begin
      exp_rd  = (rd && !wrt && ok) ? model_load(alu, sz, uns) : 32'h0;
      exp_mis = (rd || wrt) && !ok;
      exp_res = alu; exp_wb = cwb; exp_wr = wr;
      if (wrt && ok) model_store(alu, sz, wd);
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  localparam logic [4:0] C_SW  = 5'b01110;
  localparam logic [4:0] C_LW  = 5'b01101;
  localparam logic [4:0] C_SB  = 5'b00010;
  localparam logic [4:0] C_LB  = 5'b00001;
  localparam logic [4:0] C_LBU = 5'b10001;
  localparam logic [4:0] C_LH  = 5'b00101;
  localparam logic [4:0] C_LHU = 5'b10101;
  localparam logic [4:0] C_NOP = 5'b00000;

  initial begin
    logic [31:0] a;
    rst_n = 1'b0; enable = 1'b0; result_alu = '0; write_data = '0;
    ctrl_mem = '0; ctrl_wb = '0; write_reg = '0;
    exp_rd = '0; exp_res = '0; exp_wb = '0; exp_wr = '0; exp_mis = 1'b0;
    #2;
    check_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Seed the tracked region (words 0..7) so every later load is defined.
    for (int i = 0; i < 8; i++)
      do_cycle("init", 1'b1, 32'(i * 4), $urandom, C_SW, 2'b00, 5'd0);

    do_cycle("sw10", 1'b1, 32'h10, 32'h8000_00F1, C_SW, 2'b00, 5'd0);
    do_cycle("lw10", 1'b1, 32'h10, 32'h0, C_LW, 2'b11, 5'd2);
    chk("lw10_const", read_data, 32'h8000_00F1);
    do_cycle("sb11", 1'b1, 32'h11, 32'h0000_007F, C_SB, 2'b00, 5'd0);
    do_cycle("lw10b", 1'b1, 32'h10, 32'h0, C_LW, 2'b11, 5'd2);
    chk("lw10b_const", read_data, 32'h8000_7FF1);

    do_cycle("sw80", 1'b1, 32'h10, 32'h0000_0080, C_SW, 2'b00, 5'd0);
    do_cycle("lb", 1'b1, 32'h10, 32'h0, C_LB, 2'b11, 5'd3);
    chk("lb_const", read_data, 32'hFFFF_FF80);
    do_cycle("lbu", 1'b1, 32'h10, 32'h0, C_LBU, 2'b11, 5'd3);
    chk("lbu_const", read_data, 32'h0000_0080);
    do_cycle("swab", 1'b1, 32'h10, 32'hABCD_0000, C_SW, 2'b00, 5'd0);
    do_cycle("lh", 1'b1, 32'h12, 32'h0, C_LH, 2'b11, 5'd4);
    chk("lh_const", read_data, 32'hFFFF_ABCD);
    do_cycle("lhu", 1'b1, 32'h12, 32'h0, C_LHU, 2'b11, 5'd4);
    chk("lhu_const", read_data, 32'h0000_ABCD);

    do_cycle("mis_sw", 1'b1, 32'h13, 32'h1234_5678, C_SW, 2'b00, 5'd0);
    chk("mis_sw_flag", {31'd0, misaligned}, 32'd1);
    do_cycle("mis_lw", 1'b1, 32'h10, 32'h0, C_LW, 2'b11, 5'd6);
    chk("mis_lw_const", read_data, 32'hABCD_0000);
    do_cycle("mis_lh", 1'b1, 32'h11, 32'h0, C_LH, 2'b11, 5'd6);
    chk("mis_lh_const", read_data, 32'h0);

    for (int i = 0; i < 3; i++)
      do_cycle("stall", 1'b0, 32'h14, 32'hCAFE_F00D, C_SW, 2'b01, 5'd9);
    do_cycle("stall_lw", 1'b1, 32'h14, 32'h0, C_LW, 2'b11, 5'd9);
    do_cycle("release", 1'b1, 32'h14, 32'hCAFE_F00D, C_SW, 2'b01, 5'd9);
    do_cycle("after_rel", 1'b1, 32'h14, 32'h0, C_LW, 2'b11, 5'd9);
    chk("after_rel_const", read_data, 32'hCAFE_F00D);

    do_cycle("rtype", 1'b1, 32'h10, 32'hFFFF_FFFF, C_NOP, 2'b10, 5'd5);
    chk("rtype_const", res_out, 32'h10);

    // Mid-stream asynchronous reset, asserted between edges.
    do_cycle("pre_rst", 1'b1, 32'h10, 32'h0, C_LW, 2'b11, 5'd7);
    ctrl_mem = C_NOP; ctrl_wb = 2'b00;
    #3 rst_n = 1'b0;
    exp_rd = '0; exp_res = '0; exp_wb = '0; exp_wr = '0; exp_mis = 1'b0;
    #1 check_outputs("async_rst");
    @(posedge clk); #1;
    check_outputs("rst_hold");
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 31));
      do_cycle("rand", ($urandom_range(0, 9) != 0), a, $urandom,
               5'($urandom_range(0, 31)), 2'($urandom), 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tl_memory_access.md
# tl_memory_access

Memory-access stage of the pipelined MIPS: accepts the EX/MEM results, performs loads and stores against a byte-addressable data memory, and holds the MEM/WB pipeline register that feeds `tl_write_back` directly. All outputs are registered; one instruction enters per enabled clock edge.

## Interface
Parameters:
- `len`, 32, datapath width
- `NB_CTRL_WB`, 2, write-back control width
- `NB_CTRL_MEM`, 5, memory control width
- `NB_ADDRESS_REGISTROS`, 5, register-file address width
- `N_WORDS`, 256, data-memory depth in 32-bit words (power of two)

Ports:
- `i_clk`  in  1  clock, rising edge
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_enable`  in  1  stage advance (debug-unit stepping); 0 freezes all state
- `i_result_alu`  in  len  ALU result; byte address for loads/stores
- `i_write_data`  in  len  store data (rt value)
- `i_ctrl_mem`  in  NB_CTRL_MEM  [0] MemRead, [1] MemWrite, [3:2] size (00 byte, 01 half, 11 word, 10 reserved = word), [4] unsigned load
- `i_ctrl_wb`  in  NB_CTRL_WB  [1] RegWrite, [0] MemtoReg; passed through
- `i_write_reg`  in  NB_ADDRESS_REGISTROS  destination register; passed through
- `o_read_data`  out  len  extended load data → `tl_write_back.i_read_data`
- `o_result_alu`  out  len  registered ALU result → `i_result_alu`
- `o_ctrl_wb`  out  NB_CTRL_WB  → `i_ctrl_wb`
- `o_write_reg`  out  NB_ADDRESS_REGISTROS  → `i_write_reg`
- `o_misaligned`  out  1  access in MEM/WB was misaligned

## Operation
- Word index = `i_result_alu[log2(N_WORDS)+1:2]`; upper address bits ignored (wrap-around). Lane = `i_result_alu[1:0]`, little-endian (lane 0 = bits 7:0).
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00. Byte always aligned.
- Store (MemWrite=1, aligned): byte-enabled write at the clock edge. Byte: `i_write_data[7:0]` into selected lane; half: `[15:0]` into lanes 1:0 or 3:2; word: all lanes. Other lanes unchanged.
- Load (MemRead=1, aligned): selected lane(s) extracted and right-justified; sign-extended unless unsigned bit set; word loads unchanged.
- Misaligned access: store suppressed (memory unchanged), load data forced to 0, `o_misaligned`=1 for that instruction. `o_ctrl_wb` passed through unchanged.
- MemRead=MemWrite=1 (illegal): write performed, read data forced to 0.
- Neither set: no memory access, `o_read_data`=0.
- `i_enable`=0: no memory write, MEM/WB register holds.
- Memory array not cleared by reset; power-up contents 0.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on all outputs after edge N (MEM/WB register).
- Memory read synchronous at the same edge; extension applied to RAM output and captured in the same stage register (extension logic before or after RAM is implementer's choice, latency fixed at 1).
- Store at edge N followed by load of same address sampled at edge N+1: load returns new data (write visible next edge).
- Reset (any time, incl. mid-stream): all outputs 0 immediately; `o_ctrl_wb`=00 so no spurious register write; memory contents and a store coincident with reset assertion are not guaranteed, stores after deassertion proceed normally.
- First edge after `i_rst_n` rises is a normal capturing edge.

## Structure
- Shared package: `i_ctrl_mem` bit positions, size encodings (BYTE/HALF/WORD), `i_ctrl_wb` bit positions (shared with `tl_write_back` and control unit).
- Sub-module `ram_data_byte_en`: N_WORDS×32 synchronous RAM, 4-bit byte-write enable, synchronous read, no reset.
- Top: alignment check, lane/byte-enable generation, load extension, MEM/WB register.

## Test plan
- Reset: assert `i_rst_n`=0 mid-stream → all outputs 0 asynchronously, `o_ctrl_wb`=00.
- SW 0x8000_00F1 @0x10, then LW @0x10 → `o_read_data`=0x8000_00F1 one cycle after the load; SB 0x7F @0x11, LW @0x10 → 0x8000_7FF1.
- LB @0x10 after SW 0x0000_0080 → 0xFFFF_FF80; LBU → 0x0000_0080; LH @0x12 of 0xABCD_0000 → 0xFFFF_ABCD; LHU → 0x0000_ABCD.
- Misaligned SW 0x1234_5678 @0x13 → memory unchanged (LW @0x10 returns prior value), `o_misaligned`=1; LH @0x11 → `o_read_data`=0.
- `i_enable`=0 for 3 cycles with SW pending → no write, outputs frozen; release → write occurs, outputs advance.
- R-type pass-through: result_alu=0x10, ctrl_wb=10, write_reg=5 → outputs 0x10/10/5 after one edge, `o_read_data`=0.
